// File: rtl/axi_seq_msg_if.sv
// AXI-Lite bus bundle between the message sequencer (master) and the peripheral
// interconnect (slave).
interface axi_seq_msg_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0]   M_AWADDR;
  logic            M_AWVALID;
  logic            M_AWREADY;
  logic [DW-1:0]   M_WDATA;
  logic [DW/8-1:0] M_WSTRB;
  logic            M_WVALID;
  logic            M_WREADY;
  logic [1:0]      M_BRESP;
  logic            M_BVALID;
  logic            M_BREADY;
  logic [AW-1:0]   M_ARADDR;
  logic            M_ARVALID;
  logic            M_ARREADY;
  logic [DW-1:0]   M_RDATA;
  logic [1:0]      M_RRESP;
  logic            M_RVALID;
  logic            M_RREADY;

  modport master (
    output M_AWADDR, M_AWVALID, input M_AWREADY,
    output M_WDATA, M_WSTRB, M_WVALID, input M_WREADY,
    input M_BRESP, M_BVALID, output M_BREADY,
    output M_ARADDR, M_ARVALID, input M_ARREADY,
    input M_RDATA, M_RRESP, M_RVALID, output M_RREADY
  );

  modport slave (
    input M_AWADDR, M_AWVALID, output M_AWREADY,
    input M_WDATA, M_WSTRB, M_WVALID, output M_WREADY,
    output M_BRESP, M_BVALID, input M_BREADY,
    input M_ARADDR, M_ARVALID, output M_ARREADY,
    output M_RDATA, M_RRESP, M_RVALID, input M_RREADY
  );
endinterface

// File: rtl/axi_seq_msg.sv
// AXI-Lite micro-sequencer: streams bytes from a message RAM to a UART TXDATA register,
// polling STATUS before each byte. Define AXI_SEQ_TIMEOUT_EN to bound polling per byte.
module axi_seq_msg #(
  parameter int          AW           = 32,
  parameter int          DW           = 32,
  parameter logic [31:0] UART_BASE    = 32'h4000_0000,
  parameter logic [31:0] TXDATA_OFS   = 32'h0,
  parameter logic [31:0] STATUS_OFS   = 32'h8,
  parameter int          BUSY_BIT     = 0,
  parameter int          DEPTH        = 64,
  parameter int          POLL_TIMEOUT = 1024
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  input  logic                     ram_we,
  input  logic [$clog2(DEPTH)-1:0] ram_waddr,
  input  logic [7:0]               ram_wdata,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [$clog2(DEPTH)-1:0] cmd_addr,
  input  logic [$clog2(DEPTH):0]   cmd_len,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [1:0]               err_code,
  axi_seq_msg_if.master            m
);
  localparam int AL = $clog2(DEPTH);
  localparam logic [DW/8-1:0] STRB_BYTE0 = 1;

  typedef enum logic [2:0] {IDLE, POLL_AR, POLL_R, WR, WR_B, NEXT, ERR} state_t;

  state_t          state, state_next;
  logic [1:0]      code_next;
  logic [7:0]      mem [DEPTH];
  logic [AL-1:0]   ptr;
  logic [AL:0]     rem;
  logic            accept;
  logic            status_busy;
  logic            timeout_hit;
  logic            ar_valid, r_ready, aw_valid, w_valid, b_ready;
  logic [AW-1:0]   ar_addr, aw_addr;
  logic [DW-1:0]   w_data;
  logic [DW/8-1:0] w_strb;
  logic            unused_ok;

  assign accept      = cmd_ready && cmd_valid;
  assign status_busy = m.M_RDATA[BUSY_BIT];
  assign unused_ok   = ^{m.M_RDATA, 32'(POLL_TIMEOUT)};

  assign m.M_ARVALID = ar_valid;
  assign m.M_ARADDR  = ar_addr;
  assign m.M_RREADY  = r_ready;
  assign m.M_AWVALID = aw_valid;
  assign m.M_AWADDR  = aw_addr;
  assign m.M_WVALID  = w_valid;
  assign m.M_WDATA   = w_data;
  assign m.M_WSTRB   = w_strb;
  assign m.M_BREADY  = b_ready;

  always_ff @(posedge ACLK) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
  end

`ifdef AXI_SEQ_TIMEOUT_EN
  localparam int PW = $clog2(POLL_TIMEOUT + 1);
  logic [PW-1:0] poll_cnt;

  // Counts busy STATUS reads for the current byte; cleared on a non-busy read or a new command.
  assign timeout_hit = (poll_cnt == PW'(POLL_TIMEOUT - 1));

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET)
      poll_cnt <= '0;
    else if (accept)
      poll_cnt <= '0;
    else if (state == POLL_R && m.M_RVALID)
      poll_cnt <= (m.M_RRESP == 2'b00 && status_busy) ? poll_cnt + 1'b1 : '0;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_next = state;
    code_next  = err_code;
    case (state)
      IDLE:    if (accept && cmd_len != '0) state_next = POLL_AR;
      POLL_AR: if (m.M_ARREADY) state_next = POLL_R;
      POLL_R: begin
        if (m.M_RVALID) begin
          if (m.M_RRESP != 2'b00) begin
            state_next = ERR;
            code_next  = 2'b01;
          end else if (status_busy) begin
            if (timeout_hit) begin
              state_next = ERR;
              code_next  = 2'b11;
            end else begin
              state_next = POLL_AR;
            end
          end else begin
            state_next = WR;
          end
        end
      end
      // AW and W complete independently; a dropped VALID means that half is finished.
      WR: if ((!aw_valid || m.M_AWREADY) && (!w_valid || m.M_WREADY)) state_next = WR_B;
      WR_B: begin
        if (m.M_BVALID) begin
          if (m.M_BRESP != 2'b00) begin
            state_next = ERR;
            code_next  = 2'b10;
          end else begin
            state_next = NEXT;
          end
        end
      end
      NEXT:    state_next = (rem == (AL+1)'(1)) ? IDLE : POLL_AR;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_code  <= 2'b00;
      ptr       <= '0;
      rem       <= '0;
      ar_valid  <= 1'b0;
      ar_addr   <= '0;
      r_ready   <= 1'b0;
      aw_valid  <= 1'b0;
      aw_addr   <= '0;
      w_valid   <= 1'b0;
      w_data    <= '0;
      w_strb    <= '0;
      b_ready   <= 1'b0;
    end else begin
      state     <= state_next;
      cmd_ready <= (state_next == IDLE);
      busy      <= (state_next != IDLE);
      done      <= (accept && cmd_len == '0) || (state == NEXT && rem == (AL+1)'(1));
      err       <= (state == ERR);
      err_code  <= accept ? 2'b00 : code_next;

      if (accept) begin
        ptr <= cmd_addr;
        rem <= cmd_len;
      end else if (state == NEXT) begin
        ptr <= ptr + 1'b1;
        rem <= rem - 1'b1;
      end

      ar_valid <= (state_next == POLL_AR);
      ar_addr  <= AW'(UART_BASE + STATUS_OFS);
      r_ready  <= (state_next == POLL_R);
      b_ready  <= (state_next == WR_B);

      if (state != WR && state_next == WR) begin
        aw_valid <= 1'b1;
        aw_addr  <= AW'(UART_BASE + TXDATA_OFS);
        w_valid  <= 1'b1;
        w_data   <= DW'(mem[ptr]);
        w_strb   <= STRB_BYTE0;
      end else begin
        if (aw_valid && m.M_AWREADY) aw_valid <= 1'b0;
        if (w_valid && m.M_WREADY) w_valid <= 1'b0;
      end
    end
  end
endmodule
